// File: rtl/croc_pkg.sv
// Shared SoC constants used by the GPIO input conditioning path.
package croc_pkg;

  localparam int unsigned GpioCountDefault = 32;
  localparam int unsigned CntWidth         = 8;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO pin: two-flop synchronizer, saturating debounce filter and
// registered edge pulses aligned with the first cycle of the new filtered value.
module gpio_debounce
  import croc_pkg::*;
#(
  parameter int unsigned Width = CntWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  input  logic             debounce_en,
  input  logic [Width-1:0] debounce_cycles,
  output logic             gpio,
  output logic             rise,
  output logic             fall
);

  logic             meta;
  logic             sync;
  logic             filt;
  logic [Width-1:0] cnt;
  logic [Width-1:0] neff;
  logic [Width:0]   cnt_inc;
  logic             update;

  always_comb begin
    neff = debounce_cycles;
    if (!debounce_en || debounce_cycles == '0) begin
      neff = Width'(1);
    end
    // one extra bit so the all-ones count cannot wrap in the compare
    cnt_inc = {1'b0, cnt} + (Width + 1)'(1);
    update  = (sync != filt) && (cnt_inc >= {1'b0, neff});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= pad;
      sync <= meta;
      rise <= update & sync;
      fall <= update & ~sync;
      if (sync == filt) begin
        cnt <= '0;
      end else if (update) begin
        filt <= sync;
        cnt  <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt_inc[Width-1:0];
      end
    end
  end

  assign gpio = filt;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning between the pad p2c nets and the SoC gpio inputs:
// per-pin debounce/edge detection plus sticky event flags and a shared irq.
module gpio_in_filter
  import croc_pkg::*;
#(
  parameter int unsigned GpioCount = GpioCountDefault,
  parameter int unsigned CntW      = CntWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GpioCount-1:0] pad_gpio_i,
  input  logic [GpioCount-1:0] debounce_en_i,
  input  logic [CntW-1:0]      debounce_cycles_i,
  input  logic [GpioCount-1:0] rise_en_i,
  input  logic [GpioCount-1:0] fall_en_i,
  input  logic [GpioCount-1:0] event_clr_i,
  output logic [GpioCount-1:0] gpio_o,
  output logic [GpioCount-1:0] rise_o,
  output logic [GpioCount-1:0] fall_o,
  output logic [GpioCount-1:0] event_o,
  output logic                 irq_o
);

  logic [GpioCount-1:0] flags;
  logic [GpioCount-1:0] set;

  for (genvar i = 0; i < GpioCount; i++) begin : g_pin
    gpio_debounce #(
      .Width(CntW)
    ) u_debounce (
      .clk            (clk_i),
      .rst            (rst_i),
      .pad            (pad_gpio_i[i]),
      .debounce_en    (debounce_en_i[i]),
      .debounce_cycles(debounce_cycles_i),
      .gpio           (gpio_o[i]),
      .rise           (rise_o[i]),
      .fall           (fall_o[i])
    );
  end

  assign set = (rise_o & rise_en_i) | (fall_o & fall_en_i);

  // a new event in the same cycle as a clear must not be lost
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~event_clr_i) | set;
    end
  end

  assign event_o = flags;
  assign irq_o   = |flags;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: bypass, debounce, events, threshold
// changes and reset behaviour, with hand-computed expectations.
module tb_gpio_in_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pad = '0;
  logic [31:0] den = '0;
  logic [7:0]  dcyc = '0;
  logic [31:0] ren = '0;
  logic [31:0] fen = '0;
  logic [31:0] clr = '0;
  logic [31:0] gpio;
  logic [31:0] rise;
  logic [31:0] fall;
  logic [31:0] ev;
  logic        irq;

  int total = 0;
  int bad   = 0;

  gpio_in_filter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pad_gpio_i       (pad),
    .debounce_en_i    (den),
    .debounce_cycles_i(dcyc),
    .rise_en_i        (ren),
    .fall_en_i        (fen),
    .event_clr_i      (clr),
    .gpio_o           (gpio),
    .rise_o           (rise),
    .fall_o           (fall),
    .event_o          (ev),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pad = '1;
    repeat (3) tick();
    total++; if (gpio !== 32'h0) begin bad++; $display("FAIL reset_gpio got=%h exp=%h", gpio, 32'h0); end
    total++; if (rise !== 32'h0 || fall !== 32'h0) begin bad++; $display("FAIL reset_edges rise=%h fall=%h exp=0", rise, fall); end
    total++; if (ev !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL reset_event ev=%h irq=%b exp=0", ev, irq); end
    rst = 1'b0;
    repeat (2) tick();
    total++; if (gpio !== 32'h0) begin bad++; $display("FAIL reset_hold_lat2 got=%h exp=%h", gpio, 32'h0); end
    tick();
    total++; if (gpio !== 32'hFFFF_FFFF || rise !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_hold_rise gpio=%h rise=%h exp=ffffffff", gpio, rise); end
    tick();
    total++; if (rise !== 32'h0) begin bad++; $display("FAIL reset_hold_pulse1 got=%h exp=0", rise); end
    pad = '0;
    repeat (3) tick();
    total++; if (gpio !== 32'h0 || fall !== 32'hFFFF_FFFF) begin bad++; $display("FAIL all_fall gpio=%h fall=%h exp gpio=0 fall=ffffffff", gpio, fall); end
    tick();
    total++; if (fall !== 32'h0) begin bad++; $display("FAIL all_fall_pulse1 got=%h exp=0", fall); end
  endtask

  task automatic test_bypass();
    pad[0] = 1'b1;
    repeat (2) tick();
    total++; if (gpio !== 32'h0 || rise !== 32'h0) begin bad++; $display("FAIL bypass_lat2 gpio=%h rise=%h exp=0", gpio, rise); end
    tick();
    total++; if (gpio !== 32'h1 || rise !== 32'h1) begin bad++; $display("FAIL bypass_lat3 gpio=%h rise=%h exp=1", gpio, rise); end
    tick();
    total++; if (gpio !== 32'h1 || rise !== 32'h0) begin bad++; $display("FAIL bypass_after gpio=%h rise=%h exp gpio=1 rise=0", gpio, rise); end
    pad[0] = 1'b0;
    repeat (3) tick();
    total++; if (gpio !== 32'h0 || fall !== 32'h1) begin bad++; $display("FAIL bypass_fall gpio=%h fall=%h exp gpio=0 fall=1", gpio, fall); end
  endtask

  task automatic test_debounce();
    logic seen;
    den = 32'h2;
    dcyc = 8'd10;
    pad[1] = 1'b1;
    repeat (6) tick();
    pad[1] = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | gpio[1] | rise[1];
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_reject seen=%b exp=0", seen); end
    pad[1] = 1'b1;
    repeat (11) tick();
    total++; if (gpio[1] !== 1'b0) begin bad++; $display("FAIL debounce_early got=%b exp=0", gpio[1]); end
    tick();
    total++; if (gpio[1] !== 1'b1 || rise[1] !== 1'b1) begin bad++; $display("FAIL debounce_c12 gpio=%b rise=%b exp=1", gpio[1], rise[1]); end
  endtask

  task automatic test_events();
    ren = 32'h4;
    pad[2] = 1'b1;
    repeat (3) tick();
    total++; if (rise[2] !== 1'b1 || ev !== 32'h0) begin bad++; $display("FAIL event_pre rise=%b ev=%h exp rise=1 ev=0", rise[2], ev); end
    tick();
    total++; if (ev !== 32'h4 || irq !== 1'b1) begin bad++; $display("FAIL event_set ev=%h irq=%b exp ev=4 irq=1", ev, irq); end
    pad[2] = 1'b0;
    repeat (3) tick();
    total++; if (fall[2] !== 1'b1) begin bad++; $display("FAIL event_fall got=%b exp=1", fall[2]); end
    tick();
    total++; if (ev !== 32'h4) begin bad++; $display("FAIL event_fall_off ev=%h exp=4", ev); end
    clr = 32'h4;
    tick();
    clr = '0;
    total++; if (ev !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL event_clr ev=%h irq=%b exp=0", ev, irq); end
  endtask

  task automatic test_clear_collision();
    ren = 32'hC;
    pad[3] = 1'b1;
    repeat (3) tick();
    total++; if (rise[3] !== 1'b1) begin bad++; $display("FAIL coll_rise got=%b exp=1", rise[3]); end
    clr = 32'h8;
    tick();
    clr = '0;
    total++; if (ev !== 32'h8 || irq !== 1'b1) begin bad++; $display("FAIL coll_keep ev=%h irq=%b exp ev=8 irq=1", ev, irq); end
    clr = 32'h8;
    tick();
    clr = '0;
    total++; if (ev !== 32'h0) begin bad++; $display("FAIL coll_clr ev=%h exp=0", ev); end
  endtask

  task automatic test_threshold();
    den = 32'h12;
    dcyc = 8'd200;
    pad[4] = 1'b1;
    repeat (52) tick();
    total++; if (gpio[4] !== 1'b0) begin bad++; $display("FAIL thr_pending got=%b exp=0", gpio[4]); end
    dcyc = 8'd20;
    tick();
    total++; if (gpio[4] !== 1'b1 || rise[4] !== 1'b1) begin bad++; $display("FAIL thr_lower gpio=%b rise=%b exp=1", gpio[4], rise[4]); end
    pad[4] = 1'b0;
    repeat (12) tick();
    dcyc = 8'd30;
    repeat (10) tick();
    total++; if (gpio[4] !== 1'b1) begin bad++; $display("FAIL thr_raise_hold got=%b exp=1", gpio[4]); end
    repeat (10) tick();
    total++; if (gpio[4] !== 1'b0 || fall[4] !== 1'b1) begin bad++; $display("FAIL thr_raise_done gpio=%b fall=%b exp gpio=0 fall=1", gpio[4], fall[4]); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] seen;
    pad = '0;
    ren = '0;
    den = 32'h20;
    dcyc = 8'd10;
    repeat (30) tick();
    pad[5] = 1'b1;
    repeat (7) tick();
    total++; if (gpio[5] !== 1'b0) begin bad++; $display("FAIL mid_pending got=%b exp=0", gpio[5]); end
    rst = 1'b1;
    tick();
    total++; if (gpio !== 32'h0 || rise !== 32'h0 || fall !== 32'h0 || ev !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL mid_reset gpio=%h rise=%h fall=%h ev=%h irq=%b exp=0", gpio, rise, fall, ev, irq); end
    rst = 1'b0;
    seen = '0;
    repeat (11) begin
      tick();
      seen = seen | gpio | rise | fall;
    end
    total++; if (seen !== 32'h0) begin bad++; $display("FAIL mid_quiet got=%h exp=0", seen); end
    tick();
    total++; if (gpio !== 32'h20 || rise !== 32'h20) begin bad++; $display("FAIL mid_rise12 gpio=%h rise=%h exp=20", gpio, rise); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_debounce();
    test_events();
    test_clear_collision();
    test_threshold();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
